hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised successor to the decode-stage stall logic: a per-register countdown scoreboard.
//  Sits between decode and execute, tracks in-flight writers with variable result latency, and
//  stalls decode on RAW, WAW and non-pipelined-unit structural hazards.
//  Replaces fixed EX/MEM/WB address compares, so long ops (load, mul/div) stall only as long as needed.
// PARAMETERS
//  NREGS       32  architectural registers; x0 is never tracked
//  ADDR_W      $clog2(NREGS)  register address width
//  MAX_LAT     8   maximum result latency in cycles; larger requests saturate to MAX_LAT
//  PIPE_TO_WB  3   extra cycles from result-ready to register-file write (used when forwarding is off)
//  LAT_W       $clog2(MAX_LAT+PIPE_TO_WB+1)  width of the countdown counters
// PORTS
//  clk_i              in   1       clock
//  rst_ni             in   1       asynchronous reset, active low
//  decode_valid_i     in   1       decode holds a valid instruction
//  decode_rs1_addr_i  in   ADDR_W  source 1 address
//  decode_rs1_used_i  in   1       source 1 is read by the instruction
//  decode_rs2_addr_i  in   ADDR_W  source 2 address
//  decode_rs2_used_i  in   1       source 2 is read by the instruction
//  decode_rd_addr_i   in   ADDR_W  destination address
//  decode_regwen_i    in   1       instruction writes rd
//  decode_lat_i       in   LAT_W   result latency in cycles; 0 is treated as 1
//  decode_nonpipe_i   in   1       instruction uses the non-pipelined unit (mul/div)
//  flush_i            in   1       redirect from execute; kill the decode instruction
//  stall_o            out  1       hold PC and IF/ID registers
//  flush_e_o          out  1       insert a bubble into the ID/EX registers
//  sb_busy_o          out  NREGS   registered: bit r = count[r] != 0
// BEHAVIOUR
//  - Effective latency: L = max(decode_lat_i,1), capped at MAX_LAT; E = L-1 (+PIPE_TO_WB if no fwd).
//  - Issue condition: issue = decode_valid_i & !stall_o & !flush_i.
//  - RAW: stall if any used rsN != 0 and count[rsN] != 0.
//  - WAW: stall if decode_regwen_i, rd != 0, and count[rd] > E, so writes never complete out of order.
//  - Structural: stall if decode_nonpipe_i and unit_cnt != 0.
//  - stall_o is combinational, gated by decode_valid_i. flush_i forces stall_o = 0.
//  - flush_e_o = stall_o | flush_i.
//  - Per-cycle counter update, per register r:
//      issue & regwen & rd == r & r != 0  ->  count[r] <= E   (issue wins over decrement)
//      else if count[r] != 0              ->  count[r] - 1
//  - unit_cnt follows the same rule: loaded with E on issue of a non-pipelined op, then decrements.
//  - Latency examples with forwarding: L=1 never stalls a back-to-back consumer; L=2 gives 1 stall cycle.
//  - flush_i does not clear counters: older in-flight instructions still complete.
//  - Reset (async, any cycle, including mid-countdown): all counters and unit_cnt = 0,
//    sb_busy_o = 0, stall_o = 0, flush_e_o = 0.
//  - Decrement never wraps below 0. rd = 0 never loads a counter, and reads of x0 never stall.
// CONFIGURATION
//  HAZARD_SCOREBOARD_FWD_EN
//    defined:   E = L-1; consumers are released when the result can be forwarded.
//    undefined: E = L-1+PIPE_TO_WB; consumers wait for the register-file write (no bypass network).
// STRUCTURE
//  - hazard_pkg holds: lat_t (logic [LAT_W-1:0]), function eff_lat(), MAX_LAT and PIPE_TO_WB defaults.
//  - Sub-module sb_counter: one loadable saturating-at-zero down-counter with a nonzero flag.
//    Instantiated NREGS-1 times for the registers, plus once for unit_cnt.
//  - Top level holds only the read muxes, hazard compares and issue logic.
// TESTING
//  1. Reset: rst_ni=0, then release -> sb_busy_o=0; rs1=5 used -> stall_o=0.
//  2. ALU back-to-back (FWD_EN): issue rd=3 lat=1, next rs2=3 -> stall_o=0 every cycle.
//  3. Load-use (FWD_EN): issue rd=5 lat=2, next rs1=5 -> stall_o=1 for 1 cycle, issue on the 2nd.
//     Without FWD_EN and PIPE_TO_WB=3 -> 4 stall cycles.
//  4. Long op: issue rd=7 lat=8 nonpipe.
//     Next rs1=7 -> 7 stall cycles.
//     Independent nonpipe op -> 7 stall cycles.
//     rd=7 lat=1 (WAW) -> stalls until count[7]==0.
//  5. x0: issue rd=0 lat=8 -> sb_busy_o[0]=0; consumer rs1=0 -> no stall.
//  6. Flush/reset: flush_i=1 during a RAW stall -> stall_o=0, flush_e_o=1, no counter load.
//     count[7] keeps decrementing; rst_ni=0 with count[7]=4 -> all counters 0 immediately.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and latency helper for the hazard scoreboard.
// HAZARD_SCOREBOARD_FWD_EN selects forwarded (L-1) versus writeback-timed (L-1+PIPE_TO_WB) release.
package hazard_pkg;

    localparam int MAX_LAT    = 8;
    localparam int PIPE_TO_WB = 3;
    localparam int LAT_W      = $clog2(MAX_LAT + PIPE_TO_WB + 1);

    typedef logic [LAT_W-1:0] lat_t;

    // Cycles a consumer must wait after issue: latency 0 behaves as 1, long requests saturate.
    function automatic lat_t eff_lat(input lat_t lat);
        lat_t l;
        l = (lat == '0) ? lat_t'(1) : lat;
        if (l > lat_t'(MAX_LAT)) l = lat_t'(MAX_LAT);
`ifdef HAZARD_SCOREBOARD_FWD_EN
        return l - lat_t'(1);
`else
        return l - lat_t'(1) + lat_t'(PIPE_TO_WB);
`endif
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_counter.sv
// sb_counter: loadable down-counter that holds at zero, with a nonzero flag.
// Used per tracked register and for the non-pipelined unit (HAZARD_SCOREBOARD_FWD_EN only affects load values).
module sb_counter #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] count_o,
    output logic         busy_o
);

    logic [W-1:0] count_q;

    // A load in the same cycle as a pending decrement takes priority.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    assign count_o = count_q;
    assign busy_o  = (count_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage countdown scoreboard: stalls on RAW, WAW and non-pipelined-unit hazards.
// Build with HAZARD_SCOREBOARD_FWD_EN when a bypass network releases consumers at result time.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREGS  = 32,
    parameter int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              decode_valid_i,
    input  logic [ADDR_W-1:0] decode_rs1_addr_i,
    input  logic              decode_rs1_used_i,
    input  logic [ADDR_W-1:0] decode_rs2_addr_i,
    input  logic              decode_rs2_used_i,
    input  logic [ADDR_W-1:0] decode_rd_addr_i,
    input  logic              decode_regwen_i,
    input  lat_t              decode_lat_i,
    input  logic              decode_nonpipe_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              flush_e_o,
    output logic [NREGS-1:0]  sb_busy_o
);

    // Handshake: decode offers an instruction with decode_valid_i; it is accepted (issued) in a
    // cycle where stall_o is low and flush_i is low, otherwise decode holds it or it is killed.
    logic [NREGS-1:0][LAT_W-1:0] cnt;
    logic [NREGS-1:0]            busy;
    lat_t                        e_lat;
    logic                        issue;
    logic                        raw_hz, waw_hz, struct_hz;
    logic                        unit_busy;
    lat_t                        unused_unit_cnt;

    assign e_lat = eff_lat(decode_lat_i);

    // x0 is hardwired idle so reads and writes of it never interact with the scoreboard.
    assign cnt[0]  = '0;
    assign busy[0] = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_reg
        sb_counter #(.W(LAT_W)) u_cnt (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .load_i     (issue & decode_regwen_i & (decode_rd_addr_i == ADDR_W'(r))),
            .load_val_i (e_lat),
            .count_o    (cnt[r]),
            .busy_o     (busy[r])
        );
    end

    sb_counter #(.W(LAT_W)) u_unit (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (issue & decode_nonpipe_i),
        .load_val_i (e_lat),
        .count_o    (unused_unit_cnt),
        .busy_o     (unit_busy)
    );

    assign raw_hz = (decode_rs1_used_i & (decode_rs1_addr_i != '0) & busy[decode_rs1_addr_i])
                  | (decode_rs2_used_i & (decode_rs2_addr_i != '0) & busy[decode_rs2_addr_i]);

    // A new writer may not finish before an older writer of the same register.
    assign waw_hz = decode_regwen_i & (decode_rd_addr_i != '0) & (cnt[decode_rd_addr_i] > e_lat);

    assign struct_hz = decode_nonpipe_i & unit_busy;

    assign stall_o   = decode_valid_i & ~flush_i & (raw_hz | waw_hz | struct_hz);
    assign flush_e_o = stall_o | flush_i;
    assign issue     = decode_valid_i & ~stall_o & ~flush_i;
    assign sb_busy_o = busy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard against a timestamp-based reference model.
// Expectations follow HAZARD_SCOREBOARD_FWD_EN the same way the design does.
module tb_hazard_scoreboard;

`ifdef HAZARD_SCOREBOARD_FWD_EN
    localparam int EXTRA = 0;
`else
    localparam int EXTRA = 3;
`endif
    localparam int NREGS = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic             decode_valid_i = 1'b0;
    logic [4:0]       decode_rs1_addr_i = '0;
    logic             decode_rs1_used_i = 1'b0;
    logic [4:0]       decode_rs2_addr_i = '0;
    logic             decode_rs2_used_i = 1'b0;
    logic [4:0]       decode_rd_addr_i = '0;
    logic             decode_regwen_i = 1'b0;
    logic [3:0]       decode_lat_i = '0;
    logic             decode_nonpipe_i = 1'b0;
    logic             flush_i = 1'b0;
    logic             stall_o;
    logic             flush_e_o;
    logic [NREGS-1:0] sb_busy_o;

    hazard_scoreboard dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .decode_valid_i    (decode_valid_i),
        .decode_rs1_addr_i (decode_rs1_addr_i),
        .decode_rs1_used_i (decode_rs1_used_i),
        .decode_rs2_addr_i (decode_rs2_addr_i),
        .decode_rs2_used_i (decode_rs2_used_i),
        .decode_rd_addr_i  (decode_rd_addr_i),
        .decode_regwen_i   (decode_regwen_i),
        .decode_lat_i      (decode_lat_i),
        .decode_nonpipe_i  (decode_nonpipe_i),
        .flush_i           (flush_i),
        .stall_o           (stall_o),
        .flush_e_o         (flush_e_o),
        .sb_busy_o         (sb_busy_o)
    );

    // ---------------- scoreboard / model ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [NREGS+1:0] exp_q[$];   // {stall, flush_e, busy}

    // Model: absolute cycle at which each register (and the unit) becomes free.
    longint cyc = 0;
    longint ready_at [NREGS];
    longint unit_ready = 0;

    logic             obs_stall;
    logic             obs_flush_e;
    logic [NREGS-1:0] obs_busy;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic longint remaining(input int r);
        if (r == 0 || ready_at[r] <= cyc) return 0;
        return ready_at[r] - cyc;
    endfunction

    function automatic int release_delay(input int lat);
        int l;
        l = (lat == 0) ? 1 : lat;
        if (l > 8) l = 8;
        return l - 1 + EXTRA;
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < NREGS; r++) ready_at[r] = 0;
        unit_ready = 0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_instr(input logic v, input int rs1, input logic u1, input int rs2,
                             input logic u2, input int rd, input logic wen, input int lat,
                             input logic np, input logic fl);
        decode_valid_i    = v;
        decode_rs1_addr_i = 5'(rs1);
        decode_rs1_used_i = u1;
        decode_rs2_addr_i = 5'(rs2);
        decode_rs2_used_i = u2;
        decode_rd_addr_i  = 5'(rd);
        decode_regwen_i   = wen;
        decode_lat_i      = 4'(lat);
        decode_nonpipe_i  = np;
        flush_i           = fl;
    endtask

    task automatic set_idle();
        set_instr(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    // One clock: compare against the model at the negedge, then advance the model at the posedge.
    task automatic cycle_step();
        logic [NREGS-1:0] eb;
        logic [NREGS+1:0] e;
        logic raw, waw, str, es, iss;
        int e_lat;
        @(negedge clk);
        for (int r = 0; r < NREGS; r++) eb[r] = (remaining(r) != 0);
        e_lat = release_delay(int'(decode_lat_i));
        raw = (decode_rs1_used_i && remaining(int'(decode_rs1_addr_i)) != 0)
           || (decode_rs2_used_i && remaining(int'(decode_rs2_addr_i)) != 0);
        waw = decode_regwen_i && remaining(int'(decode_rd_addr_i)) > e_lat;
        str = decode_nonpipe_i && unit_ready > cyc;
        es  = decode_valid_i && !flush_i && (raw || waw || str);
        iss = decode_valid_i && !es && !flush_i;
        exp_q.push_back({es, es | flush_i, eb});
        obs_stall   = stall_o;
        obs_flush_e = flush_e_o;
        obs_busy    = sb_busy_o;
        e = exp_q.pop_front();
        check("stall", 64'(obs_stall), 64'(e[NREGS+1]));
        check("flush_e", 64'(obs_flush_e), 64'(e[NREGS]));
        check("busy", 64'(obs_busy), 64'(e[NREGS-1:0]));
        @(posedge clk);
        if (iss && decode_regwen_i && decode_rd_addr_i != 0)
            ready_at[decode_rd_addr_i] = cyc + e_lat + 1;
        if (iss && decode_nonpipe_i) unit_ready = cyc + e_lat + 1;
        cyc++;
        #1;
    endtask

    task automatic drain();
        set_idle();
        repeat (16) cycle_step();
    endtask

    // Hold the current instruction until it issues; bounded so a stuck stall still terminates.
    task automatic run_until_issue(output int stalls);
        stalls = 0;
        for (int i = 0; i < 40; i++) begin
            cycle_step();
            if (!obs_stall) break;
            stalls++;
        end
        set_idle();
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_ni = 1'b0;
        set_instr(1'b1, 7, 1'b1, 0, 1'b0, 0, 1'b0, 1, 1'b0, 1'b0);
        #1;
        model_reset();
        check("rst_busy", 64'(sb_busy_o), 64'(0));
        check("rst_stall", 64'(stall_o), 64'(0));
        check("rst_flush_e", 64'(flush_e_o), 64'(0));
        set_idle();
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s;
        model_reset();
        apply_reset();

        // Reset state, then a consumer of x5 on an empty board.
        check("reset_busy", 64'(sb_busy_o), 64'(0));
        set_instr(1'b1, 5, 1'b1, 0, 1'b0, 0, 1'b0, 1, 1'b0, 1'b0);
        run_until_issue(s);
        check("reset_no_stall", 64'(s), 64'(0));

        // Single-cycle producer followed by a consumer on rs2.
        drain();
        set_instr(1'b1, 0, 1'b0, 0, 1'b0, 3, 1'b1, 1, 1'b0, 1'b0);
        run_until_issue(s);
        set_instr(1'b1, 0, 1'b0, 3, 1'b1, 4, 1'b1, 1, 1'b0, 1'b0);
        run_until_issue(s);
        check("alu_b2b_stalls", 64'(s), 64'(EXTRA));

        // Load-use.
        drain();
        set_instr(1'b1, 0, 1'b0, 0, 1'b0, 5, 1'b1, 2, 1'b0, 1'b0);
        run_until_issue(s);
        set_instr(1'b1, 5, 1'b1, 0, 1'b0, 6, 1'b1, 1, 1'b0, 1'b0);
        run_until_issue(s);
        check("load_use_stalls", 64'(s), 64'(1 + EXTRA));

        // Long non-pipelined op: RAW consumer, structural follower, WAW follower.
        drain();
        set_instr(1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1, 8, 1'b1, 1'b0);
        run_until_issue(s);
        set_instr(1'b1, 7, 1'b1, 0, 1'b0, 8, 1'b1, 1, 1'b0, 1'b0);
        run_until_issue(s);
        check("long_raw_stalls", 64'(s), 64'(7 + EXTRA));

        drain();
        set_instr(1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1, 8, 1'b1, 1'b0);
        run_until_issue(s);
        set_instr(1'b1, 1, 1'b1, 2, 1'b1, 9, 1'b1, 8, 1'b1, 1'b0);
        run_until_issue(s);
        check("struct_stalls", 64'(s), 64'(7 + EXTRA));

        drain();
        set_instr(1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1, 8, 1'b1, 1'b0);
        run_until_issue(s);
        set_instr(1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1, 1, 1'b0, 1'b0);
        run_until_issue(s);
        check("waw_stalls", 64'(s), 64'(7));

        // x0 is never tracked; latency saturation via lat=15.
        drain();
        set_instr(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b1, 8, 1'b0, 1'b0);
        run_until_issue(s);
        cycle_step();
        check("x0_busy", 64'(obs_busy[0]), 64'(0));
        set_instr(1'b1, 0, 1'b1, 0, 1'b1, 2, 1'b1, 15, 1'b0, 1'b0);
        run_until_issue(s);
        check("x0_read_stalls", 64'(s), 64'(0));
        set_instr(1'b1, 2, 1'b1, 0, 1'b0, 3, 1'b1, 1, 1'b0, 1'b0);
        run_until_issue(s);
        check("sat_lat_stalls", 64'(s), 64'(7 + EXTRA));

        // Flush during a RAW stall, then async reset mid-countdown.
        drain();
        set_instr(1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1, 8, 1'b1, 1'b0);
        run_until_issue(s);
        set_instr(1'b1, 7, 1'b1, 0, 1'b0, 9, 1'b1, 8, 1'b0, 1'b1);
        cycle_step();
        check("flush_stall", 64'(obs_stall), 64'(0));
        check("flush_flush_e", 64'(obs_flush_e), 64'(1));
        set_idle();
        cycle_step();
        check("flush_no_load", 64'(obs_busy[9]), 64'(0));
        check("flush_keeps_7", 64'(obs_busy[7]), 64'(1));
        repeat (7 + EXTRA - 6) cycle_step();
        check("pre_reset_busy7", 64'(remaining(7)), 64'(4));
        apply_reset();
        cycle_step();
        check("post_reset_busy", 64'(obs_busy), 64'(0));

        // Randomized traffic, small register window to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            set_instr(1'($urandom_range(0, 3) != 0),
                      int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 15)), 1'($urandom_range(0, 4) == 0),
                      1'($urandom_range(0, 7) == 0));
            cycle_step();
            if (i == 300) apply_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
